// File: rtl/fpu_div_exp_pkg.sv
// fpu_div_exp_pkg: shared FSM encoding, single-precision constants and double-bias helper
package fpu_div_exp_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADD, ST_NRM1, ST_NRM2, ST_WAIT, ST_CHK, ST_OUT
    } state_t;
    localparam int SGL_BIAS = 127;
    localparam int SGL_MAX  = 255;
    function automatic int dbl_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction
endpackage

// File: rtl/fpu_div_exp_ctl_dp_if.sv
// fpu_div_exp_ctl_dp_if: operand/result handshake bundle of the divide exponent datapath
interface fpu_div_exp_ctl_dp_if #(
    parameter int EXP_W = 11,
    parameter int SHC_W = 6,
    parameter int INT_W = EXP_W + 2
);
    logic             in_vld, in_rdy, in_dbl;
    logic [EXP_W-1:0] in_exp1, in_exp2;
    logic [SHC_W-1:0] in_shc1, in_shc2;
    logic             frac_done, frac_ovf, rnd_to_inf;
    logic             out_vld, out_rdy;
    logic [EXP_W-1:0] out_exp;
    logic [INT_W-1:0] out_exp_raw;
    logic             out_of, out_uf, busy;
    modport slave (
        input  in_vld, in_dbl, in_exp1, in_exp2, in_shc1, in_shc2,
               frac_done, frac_ovf, rnd_to_inf, out_rdy,
        output in_rdy, out_vld, out_exp, out_exp_raw, out_of, out_uf, busy
    );
    modport master (
        output in_vld, in_dbl, in_exp1, in_exp2, in_shc1, in_shc2,
               frac_done, frac_ovf, rnd_to_inf, out_rdy,
        input  in_rdy, out_vld, out_exp, out_exp_raw, out_of, out_uf, busy
    );
endinterface

// File: rtl/fpu_div_exp_clamp.sv
// fpu_div_exp_clamp: overflow/underflow clamp of the signed raw quotient exponent
module fpu_div_exp_clamp
    import fpu_div_exp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int INT_W = EXP_W + 2
) (
    input  logic signed [INT_W-1:0] raw,
    input  logic                    dbl,
    input  logic                    rnd_to_inf,
    output logic [EXP_W-1:0]        exp,
    output logic                    of,
    output logic                    uf
);
    localparam logic signed [INT_W-1:0] ZERO = '0;
    logic [EXP_W-1:0] max_e;
    assign max_e = dbl ? '1 : EXP_W'(SGL_MAX);
    always_comb begin
        of  = raw >= $signed(INT_W'(max_e));
        uf  = raw <= ZERO;
        exp = of ? (rnd_to_inf ? max_e : max_e - EXP_W'(1)) : uf ? '0 : raw[EXP_W-1:0];
    end
endmodule

// File: rtl/fpu_div_exp_ctl_dp.sv
// fpu_div_exp_ctl_dp: self-sequenced divide exponent datapath (e1 - e2 + bias, normalise, clamp).
// Optional saturating handshake statistics under FPU_DIV_EXP_STAT_EN.
module fpu_div_exp_ctl_dp
    import fpu_div_exp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int SHC_W = 6,
    parameter int INT_W = EXP_W + 2
) (
    input logic rclk,
    input logic reset,
    fpu_div_exp_ctl_dp_if.slave io
`ifdef FPU_DIV_EXP_STAT_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_of,
    output logic [15:0] stat_uf
`endif
);
    localparam logic [INT_W-1:0] DBIAS = INT_W'(dbl_bias(EXP_W));
    localparam logic [INT_W-1:0] SBIAS = INT_W'(SGL_BIAS);
    localparam logic [EXP_W-1:0] SMASK = EXP_W'(SGL_MAX);

    state_t state, nxt;
    logic [EXP_W-1:0] e1, e2, exp_q, c_exp;
    logic [SHC_W-1:0] s1, s2;
    logic [INT_W-1:0] exp1;
    logic signed [INT_W-1:0] raw;
    logic dbl, rnd, pend, pend_ovf, pend_rnd, of_q, uf_q, c_of, c_uf, take, ovf, early;

    // a frac_done seen before WAIT is parked here so WAIT can consume it immediately
    assign early = state == ST_ADD || state == ST_NRM1 || state == ST_NRM2;
    assign take  = pend || io.frac_done;
    assign ovf   = pend ? pend_ovf : io.frac_ovf;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: nxt = io.in_vld ? ST_ADD : ST_IDLE;
            ST_ADD:  nxt = ST_NRM1;
            ST_NRM1: nxt = ST_NRM2;
            ST_NRM2: nxt = ST_WAIT;
            ST_WAIT: nxt = take ? ST_CHK : ST_WAIT;
            ST_CHK:  nxt = ST_OUT;
            ST_OUT:  nxt = io.out_rdy ? ST_IDLE : ST_OUT;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            state <= ST_IDLE;
            pend  <= 1'b0;
            raw   <= '0;
            exp_q <= '0;
            of_q  <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            state <= nxt;
            if (state == ST_IDLE && io.in_vld) begin
                e1   <= io.in_dbl ? io.in_exp1 : io.in_exp1 & SMASK;
                e2   <= io.in_dbl ? io.in_exp2 : io.in_exp2 & SMASK;
                s1   <= io.in_shc1;
                s2   <= io.in_shc2;
                dbl  <= io.in_dbl;
                pend <= 1'b0;
            end
            if (state == ST_ADD)
                exp1 <= INT_W'(e1) + ~INT_W'(e2) + INT_W'(1) + (dbl ? DBIAS : SBIAS);
            if (state == ST_NRM1)
                exp1 <= exp1 - INT_W'(s1);
            if (state == ST_NRM2)
                exp1 <= exp1 + INT_W'(s2);
            if (early && io.frac_done) begin
                pend     <= 1'b1;
                pend_ovf <= io.frac_ovf;
                pend_rnd <= io.rnd_to_inf;
            end
            if (state == ST_WAIT && take) begin
                raw  <= ovf ? exp1 : exp1 - INT_W'(1);
                rnd  <= pend ? pend_rnd : io.rnd_to_inf;
                pend <= 1'b0;
            end
            if (state == ST_CHK) begin
                exp_q <= c_exp;
                of_q  <= c_of;
                uf_q  <= c_uf;
            end
        end
    end

    fpu_div_exp_clamp #(.EXP_W(EXP_W), .INT_W(INT_W)) u_clamp (
        .raw        (raw),
        .dbl        (dbl),
        .rnd_to_inf (rnd),
        .exp        (c_exp),
        .of         (c_of),
        .uf         (c_uf)
    );

    assign io.in_rdy      = state == ST_IDLE;
    assign io.out_vld     = state == ST_OUT;
    assign io.busy        = state != ST_IDLE;
    assign io.out_exp     = exp_q;
    assign io.out_exp_raw = raw;
    assign io.out_of      = of_q;
    assign io.out_uf      = uf_q;

`ifdef FPU_DIV_EXP_STAT_EN
    logic hs;
    assign hs = io.out_vld && io.out_rdy;
    always_ff @(posedge rclk) begin
        if (reset) begin
            stat_ops <= '0;
            stat_of  <= '0;
            stat_uf  <= '0;
        end else if (hs) begin
            stat_ops <= stat_ops == '1 ? stat_ops : stat_ops + 16'd1;
            stat_of  <= (!of_q || stat_of == '1) ? stat_of : stat_of + 16'd1;
            stat_uf  <= (!uf_q || stat_uf == '1) ? stat_uf : stat_uf + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fpu_div_exp_ctl_dp.sv
// tb_fpu_div_exp_ctl_dp: directed + randomized checks of the divide exponent datapath
// against an integer-arithmetic reference model (stat counters checked under FPU_DIV_EXP_STAT_EN).
module tb_fpu_div_exp_ctl_dp;
    localparam int EXP_W = 11;
    localparam int SHC_W = 6;
    localparam int INT_W = EXP_W + 2;

    logic rclk = 1'b0;
    logic reset = 1'b1;
    always #5 rclk = ~rclk;

    fpu_div_exp_ctl_dp_if #(.EXP_W(EXP_W), .SHC_W(SHC_W)) io();
`ifdef FPU_DIV_EXP_STAT_EN
    logic [15:0] stat_ops, stat_of, stat_uf;
`endif

    fpu_div_exp_ctl_dp #(.EXP_W(EXP_W), .SHC_W(SHC_W)) dut (
        .rclk  (rclk),
        .reset (reset),
        .io    (io)
`ifdef FPU_DIV_EXP_STAT_EN
        ,
        .stat_ops (stat_ops),
        .stat_of  (stat_of),
        .stat_uf  (stat_uf)
`endif
    );

    int checks = 0;
    int failures = 0;
    int n_ops = 0, n_of = 0, n_uf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // quotient exponent from the arithmetic rules, independent of any sequencing
    task automatic model(input bit dbl, input int e1, input int e2, input int s1, input int s2,
                         input bit ovf, input bit rnd,
                         output int r, output int ex, output bit of, output bit uf);
        int bias, mx, a, b;
        bias = dbl ? 1023 : 127;
        mx   = dbl ? 2047 : 255;
        a    = dbl ? e1 : e1 % 256;
        b    = dbl ? e2 : e2 % 256;
        r    = a - b + bias - s1 + s2 - (ovf ? 0 : 1);
        of   = r >= mx;
        uf   = r <= 0;
        ex   = of ? (rnd ? mx : mx - 1) : uf ? 0 : r;
    endtask

    task automatic run_op(input bit dbl, input int e1, input int e2, input int s1, input int s2,
                          input bit ovf, input bit rnd, input int d, input int stall, input string tag);
        int r, ex, k, held;
        bit of, uf;
        logic [INT_W-1:0] rr;
        model(dbl, e1, e2, s1, s2, ovf, rnd, r, ex, of, uf);
        rr = INT_W'(r);
        k = 0;
        while (!io.in_rdy && k < 20) begin
            @(negedge rclk);
            k++;
        end
        chk({tag, ".in_rdy"}, io.in_rdy, 1);
        io.in_dbl  = dbl;
        io.in_exp1 = EXP_W'(e1);
        io.in_exp2 = EXP_W'(e2);
        io.in_shc1 = SHC_W'(s1);
        io.in_shc2 = SHC_W'(s2);
        io.in_vld  = 1'b1;
        @(negedge rclk);
        io.in_vld = 1'b0;
        k = 1;
        while (!io.out_vld && k < 40) begin
            io.frac_done  = k == d;
            io.frac_ovf   = k == d ? ovf : 1'($urandom);
            io.rnd_to_inf = k == d ? rnd : 1'($urandom);
            @(negedge rclk);
            k++;
        end
        io.frac_done = 1'b0;
        chk({tag, ".lat"}, k, d + 2 > 6 ? d + 2 : 6);
        chk({tag, ".busy_rdy"}, {io.busy, io.in_rdy}, 2'b10);
        chk({tag, ".exp"}, io.out_exp, ex);
        chk({tag, ".raw"}, io.out_exp_raw, rr);
        chk({tag, ".of_uf"}, {io.out_of, io.out_uf}, {of, uf});
        held = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge rclk);
            if (io.out_vld && io.out_exp == EXP_W'(ex) && !io.in_rdy) held++;
        end
        chk({tag, ".stall_hold"}, held, stall);
        io.out_rdy = 1'b1;
        @(negedge rclk);
        io.out_rdy = 1'b0;
        n_ops++;
        n_of += int'(of);
        n_uf += int'(uf);
        chk({tag, ".after_hs"}, {io.out_vld, io.in_rdy}, 2'b01);
    endtask

    initial begin
        int quiet;
        io.in_vld = 0; io.in_dbl = 0; io.in_exp1 = '0; io.in_exp2 = '0;
        io.in_shc1 = '0; io.in_shc2 = '0; io.frac_done = 0; io.frac_ovf = 0;
        io.rnd_to_inf = 0; io.out_rdy = 0;
        reset = 1'b1;
        repeat (3) @(negedge rclk);
        chk("rst.in_rdy", io.in_rdy, 1);
        chk("rst.vld_busy", {io.out_vld, io.busy}, 2'b00);
        chk("rst.exp", io.out_exp, 0);
        chk("rst.raw", io.out_exp_raw, 0);
        chk("rst.of_uf", {io.out_of, io.out_uf}, 2'b00);
        reset = 1'b0;

        run_op(1, 'h400, 'h3FF, 0, 0, 1, 0, 1, 0, "dbl_basic");
        run_op(0, 'h080, 'h07F, 3, 1, 0, 0, 2, 1, "sgl_basic");
        run_op(1, 'h7FE, 'h001, 0, 0, 1, 1, 1, 0, "ovf_inf");
        run_op(1, 'h7FE, 'h001, 0, 0, 1, 0, 3, 0, "ovf_max");
        run_op(1, 'h001, 'h7FE, 0, 0, 0, 0, 1, 0, "unf");
        run_op(0, 'h5C0, 'h07F, 0, 0, 1, 0, 9, 0, "sgl_mask_late");
        run_op(1, 'h400, 'h3FF, 0, 0, 1, 0, 2, 3, "backpressure");

        // in_vld held across a stalled result is accepted only once back in IDLE
        io.in_dbl = 1; io.in_exp1 = 'h400; io.in_exp2 = 'h3FF; io.in_shc1 = 0; io.in_shc2 = 0;
        io.in_vld = 1;
        @(negedge rclk);
        io.frac_done = 1; io.frac_ovf = 1;
        @(negedge rclk);
        io.frac_done = 0;
        repeat (4) @(negedge rclk);
        chk("hold.out_vld", io.out_vld, 1);
        repeat (3) @(negedge rclk);
        chk("hold.stall", {io.out_vld, io.in_rdy}, 2'b10);
        io.out_rdy = 1;
        @(negedge rclk);
        io.out_rdy = 0;
        n_ops++;
        chk("hold.idle", {io.in_rdy, io.busy}, 2'b10);
        @(negedge rclk);
        io.in_vld = 0;
        chk("hold.accepted", io.busy, 1);

        // reset during WAIT discards the op; a late frac_done must not revive it
        repeat (3) @(negedge rclk);
        chk("rstw.busy_before", io.busy, 1);
        reset = 1;
        @(negedge rclk);
        reset = 0;
        n_ops = 0; n_of = 0; n_uf = 0;
        chk("rstw.state", {io.in_rdy, io.busy, io.out_vld}, 3'b100);
        io.frac_done = 1; io.frac_ovf = 1;
        @(negedge rclk);
        io.frac_done = 0;
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            if (!io.out_vld && !io.busy) quiet++;
        end
        chk("rstw.quiet", quiet, 8);

        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom), int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                   int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                   1'($urandom), 1'($urandom), int'($urandom_range(1, 8)),
                   int'($urandom_range(0, 2)), "rand");
        end

`ifdef FPU_DIV_EXP_STAT_EN
        chk("stat.ops", stat_ops, n_ops);
        chk("stat.of", stat_of, n_of);
        chk("stat.uf", stat_uf, n_uf);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpu_div_exp_ctl_dp.md
Name: fpu_div_exp_ctl_dp

Overview:
- Parametrised, self-sequenced exponent datapath for the divide pipe.
- Computes the quotient exponent e1 - e2 + bias and corrects it for dividend/divisor normalisation shifts and the quotient-normalise decrement.
- Performs overflow/underflow clamping and returns the result over a valid/ready handshake.
- Replaces externally-sequenced stage select lines with an internal FSM; generalised in exponent width and precision mode.

Parameters:
- EXP_W, 11, max exponent field width (double); legal range >= 8.
- SHC_W, 6, normalisation shift-count width.
- INT_W, EXP_W+2, internal two's-complement exponent width (derived; do not override).

Ports:
- rclk  input  1  global clock.
- reset  input  1  synchronous active-high reset.
- in_vld  input  1  operand exponents valid.
- in_rdy  output  1  block can accept an op.
- in_dbl  input  1  1 = double (bias 2^(EXP_W-1)-1); 0 = single (bias 127, exponent in low 8 bits, upper bits ignored).
- in_exp1  input  EXP_W  dividend biased exponent.
- in_exp2  input  EXP_W  divisor biased exponent.
- in_shc1  input  SHC_W  dividend leading-zero normalise count.
- in_shc2  input  SHC_W  divisor leading-zero normalise count.
- frac_done  input  1  mantissa iteration complete (pulse).
- frac_ovf  input  1  quotient mantissa >= 1.0; qualified by frac_done.
- rnd_to_inf  input  1  overflow result is infinity (else max finite); sampled with frac_done.
- out_vld  output  1  result valid.
- out_rdy  input  1  consumer accepts result.
- out_exp  output  EXP_W  clamped biased result exponent.
- out_exp_raw  output  INT_W  unclamped signed exponent, used for denormal shift.
- out_of  output  1  overflow flag.
- out_uf  output  1  underflow flag (raw <= 0).
- busy  output  1  FSM not IDLE.

Behaviour:
- Reset: state IDLE; in_rdy=1 from the cycle after reset; out_vld=0, out_of=0, out_uf=0, out_exp=0, out_exp_raw=0, busy=0.
- Reset mid-operation discards the op; no out_vld.
- IDLE: in_rdy=1. On in_vld, capture exps, shift counts and in_dbl; go to ADD.
- ADD: exp1 <= ext(e1) + ~ext(e2) + 1 + bias; go to NRM1.
- NRM1: exp1 <= exp1 - in_shc1; go to NRM2.
- NRM2: exp1 <= exp1 + in_shc2; go to WAIT.
- WAIT: hold until frac_done. Then raw <= frac_ovf ? exp1 : exp1 - 1 and latch rnd_to_inf; go to CHK.
  - frac_done arriving during ADD/NRM1/NRM2 is registered as pending and consumed on WAIT entry.
- CHK, with MAX = 2^EXP_W - 1 (double) or 255 (single); all comparisons are signed on INT_W:
  - raw >= MAX: out_of=1; out_exp = rnd_to_inf ? MAX : MAX-1.
  - raw <= 0: out_uf=1; out_exp=0.
  - else: out_exp = raw[EXP_W-1:0].
  - Go to OUT.
- OUT: out_vld=1; all outputs held stable until out_rdy; on out_rdy go to IDLE. in_rdy=0 in every non-IDLE state, so there is no overlap.
- Latency: in accept to out_vld = 5 cycles + WAIT cycles. Minimum is 5 with a pending frac_done.
- Arithmetic: all adders are INT_W wide, wrap mod 2^INT_W. INT_W guarantees no aliasing for any legal input.

Optional Feature:
- Macro: FPU_DIV_EXP_STAT_EN.
- Defined: adds output ports stat_ops[15:0], stat_of[15:0] and stat_uf[15:0].
  - Each increments on an out_vld&&out_rdy handshake (the last two only when the corresponding flag is set).
  - Each saturates at 0xFFFF and clears on reset.
- Undefined: no counters and no such ports; ports, behaviour and timing are otherwise identical.

Decomposition:
- Shared package fpu_div_exp_pkg:
  - FSM state encoding (IDLE, ADD, NRM1, NRM2, WAIT, CHK, OUT).
  - Single-precision bias 127 and single MAX 255.
  - Function computing the double bias from EXP_W.
- One sub-module, fpu_div_exp_clamp: combinational CHK logic (raw, dbl, rnd_to_inf -> out_exp, of, uf).

Test Plan:
- Double, e1=0x400, e2=0x3FF, shc=0/0, frac_done+frac_ovf=1 on cycle 1 -> out_vld 5 cycles after accept, out_exp=0x400, of=uf=0.
- Single, e1=0x080, e2=0x07F, shc1=3, shc2=1, frac_ovf=0 -> raw = 1+127-3+1-1 = 125, out_exp=0x07D.
- Double overflow, e1=0x7FE, e2=0x001, frac_ovf=1 -> raw=3068, out_of=1; rnd_to_inf=1 gives out_exp=0x7FF, rnd_to_inf=0 gives 0x7FE.
- Double underflow, e1=0x001, e2=0x7FE, frac_ovf=0 -> raw=-1023 (out_exp_raw=0x1C01), out_uf=1, out_exp=0.
- Backpressure: out_rdy=0 for 3 cycles -> out_vld and out_exp stable, in_rdy=0; in_vld held high is accepted only the cycle after the out_rdy handshake.
- Reset asserted in WAIT -> next cycle in_rdy=1, busy=0, out_vld=0; a following frac_done pulse is ignored.
